// File: rtl/game_tick_gen.sv
// Multi-channel programmable tick generator with a shared IDLE/RUN/PAUSED controller and difficulty level.
// Optional build macro TICK_TOTAL_EN adds per-channel 16-bit saturating tick counters on tick_total.
module game_tick_gen #(
    parameter int unsigned CNT_W          = 10,
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned LEVEL_W        = 3,
    parameter int unsigned DEFAULT_PERIOD = 512,
    parameter int unsigned MIN_PERIOD     = 16,
    localparam int unsigned CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               level_up,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [CNT_W-1:0]   cfg_period,
    output logic [NUM_CH-1:0]  tick,
    output logic [LEVEL_W-1:0] level,
    output logic               running
`ifdef TICK_TOTAL_EN
    ,
    output logic [NUM_CH*16-1:0] tick_total
`endif
);

    localparam logic [CNT_W-1:0] MIN_W = CNT_W'(MIN_PERIOD);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0]   base_q  [NUM_CH];
    logic [CNT_W-1:0]   base_d  [NUM_CH];
    logic [CNT_W-1:0]   count_q [NUM_CH];
    logic [CNT_W-1:0]   count_d [NUM_CH];
    logic [CNT_W-1:0]   eff     [NUM_CH];

    function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] v);
        return (v < MIN_W) ? MIN_W : v;
    endfunction

    assign running   = (state_q == RUN);
    assign cfg_ready = (state_q != RUN);
    assign level     = level_q;

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        base_d  = base_q;
        count_d = count_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            tick[i] = (state_q == RUN) && (count_q[i] == '0);
        end

        // Channel indices beyond NUM_CH match no entry, so such writes are dropped.
        if (cfg_valid && cfg_ready) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (CH_W'(i) == cfg_ch) begin
                    base_d[i] = clamp(cfg_period);
                end
            end
        end

        if ((state_q == RUN) && level_up && (level_q != '1)) begin
            level_d = level_q + 1'b1;
        end

        // Reloads use the post-update level so a level_up on a tick cycle applies at once.
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            eff[i] = clamp(base_d[i] >> level_d);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = pause ? PAUSED : RUN;
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        count_d[i] = eff[i] - 1'b1;
                    end
                end
            end
            RUN: begin
                if (pause) begin
                    state_d = PAUSED;
                end
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    count_d[i] = tick[i] ? (eff[i] - 1'b1) : (count_q[i] - 1'b1);
                end
            end
            PAUSED: begin
                if (!pause) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        if (stop) begin
            state_d = IDLE;
            level_d = '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                count_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            level_q <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                base_q[i]  <= clamp(CNT_W'(DEFAULT_PERIOD >> i));
                count_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            base_q  <= base_d;
            count_q <= count_d;
        end
    end

`ifdef TICK_TOTAL_EN
    logic [15:0] total_q [NUM_CH];

    always_ff @(posedge clk) begin
        if (reset || stop) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                total_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (tick[i] && (total_q[i] != '1)) begin
                    total_q[i] <= total_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        tick_total = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            tick_total[i*16 +: 16] = total_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_game_tick_gen.sv
// Directed bench for game_tick_gen: a cycle-level behavioural model checked every cycle,
// plus literal tick-position expectations taken from hand-worked scenarios.
module tb_game_tick_gen;

    localparam int NUM_CH  = 2;
    localparam int CNT_W   = 10;
    localparam int LEVEL_W = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset, start, stop, pause, level_up, cfg_valid, cfg_ready, running;
    logic [0:0]         cfg_ch;
    logic [CNT_W-1:0]   cfg_period;
    logic [NUM_CH-1:0]  tick;
    logic [LEVEL_W-1:0] level;
`ifdef TICK_TOTAL_EN
    logic [NUM_CH*16-1:0] tick_total;
`endif

    game_tick_gen #(
        .CNT_W(CNT_W), .NUM_CH(NUM_CH), .LEVEL_W(LEVEL_W),
        .DEFAULT_PERIOD(512), .MIN_PERIOD(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .level_up(level_up), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_period(cfg_period), .tick(tick), .level(level),
        .running(running)
`ifdef TICK_TOTAL_EN
        , .tick_total(tick_total)
`endif
    );

    int tests = 0;
    int fails = 0;
    int edges = 0;

    // Model: active/paused flags, level, base periods, cycles remaining until each tick.
    bit m_valid = 0, m_act = 0, m_pau = 0;
    int m_lvl = 0;
    int m_base [NUM_CH];
    int m_rem  [NUM_CH];
    int m_tot  [NUM_CH];

    function automatic int eff_of(int i);
        int e;
        e = m_base[i] >> m_lvl;
        return (e < 16) ? 16 : e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, edges);
        end
    endtask

    task automatic cycle();
        logic [NUM_CH-1:0] etk;
        bit run;
        run = m_act && !m_pau;
        for (int i = 0; i < NUM_CH; i++) etk[i] = run && (m_rem[i] == 1);
        if (m_valid) begin
            check("model_tick", 32'(tick), 32'(etk));
            check("model_running", 32'(running), 32'(run));
            check("model_level", 32'(level), 32'(m_lvl));
            check("model_cfg_ready", 32'(cfg_ready), 32'(!run));
`ifdef TICK_TOTAL_EN
            begin
                logic [NUM_CH*16-1:0] et;
                for (int i = 0; i < NUM_CH; i++) et[i*16 +: 16] = 16'(m_tot[i]);
                check("model_tick_total", 32'(tick_total), 32'(et));
            end
`endif
        end
        if (reset) begin
            m_valid = 1; m_act = 0; m_pau = 0; m_lvl = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_base[i] = ((512 >> i) < 16) ? 16 : (512 >> i);
                m_rem[i] = 0; m_tot[i] = 0;
            end
        end else begin
            if (!run && cfg_valid && int'(cfg_ch) < NUM_CH)
                m_base[cfg_ch] = (cfg_period < 16) ? 16 : int'(cfg_period);
            if (run && level_up && m_lvl < 7) m_lvl++;
            if (!m_act) begin
                if (start) begin
                    m_act = 1; m_pau = pause;
                    for (int i = 0; i < NUM_CH; i++) m_rem[i] = eff_of(i);
                end
            end else if (!m_pau) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (etk[i]) begin
                        m_rem[i] = eff_of(i);
                        if (m_tot[i] < 65535) m_tot[i]++;
                    end else m_rem[i]--;
                end
                if (pause) m_pau = 1;
            end else if (!pause) m_pau = 0;
            if (stop) begin
                m_act = 0; m_pau = 0; m_lvl = 0;
                for (int i = 0; i < NUM_CH; i++) begin m_rem[i] = 0; m_tot[i] = 0; end
            end
        end
        @(posedge clk);
        #1;
        edges++;
    endtask

    // Tick seen now is consumed by the next edge, so it is reported at edges+1.
    task automatic wait_tick(input int ch, output int at);
        int budget = 3000;
        while (tick[ch] !== 1'b1 && budget > 0) begin
            cycle();
            budget--;
        end
        if (budget == 0) begin
            tests++; fails++;
            $display("FAIL wait_tick_ch%0d: got timeout expected tick", ch);
        end
        at = edges + 1;
    endtask

    task automatic expect_tick(input int ch, input int exp, input string name);
        int at;
        wait_tick(ch, at);
        check(name, at, exp);
        cycle();
    endtask

    task automatic do_start();
        start = 1; cycle(); start = 0;
        edges = 0;
    endtask

    task automatic do_stop();
        stop = 1; cycle(); stop = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tick"}, 32'(tick), 0);
        check({tag, "_level"}, 32'(level), 0);
        check({tag, "_running"}, 32'(running), 0);
        check({tag, "_cfg_ready"}, 32'(cfg_ready), 1);
    endtask

    initial begin
        int at;
        reset = 1; start = 0; stop = 0; pause = 0; level_up = 0;
        cfg_valid = 0; cfg_ch = '0; cfg_period = '0;
        cycle(); cycle();
        reset = 0;
        check_reset_vals("reset");

        // Default rates, plus a start pulse in RUN that must be ignored.
        do_start();
        expect_tick(1, 256, "t1_ch1_first");
        start = 1; cycle(); start = 0;
        wait_tick(1, at);
        check("t1_ch1_second", at, 512);
        check("t1_ch0_together", 32'(tick[0]), 1);
        cycle();
        expect_tick(1, 768, "t1_ch1_third");
        expect_tick(0, 1024, "t1_ch0_second");
        do_stop();

        // Pause across edges 200..299 shifts every tick by 100.
        do_start();
        while (edges < 199) cycle();
        pause = 1;
        repeat (100) cycle();
        check("t2_running_paused", 32'(running), 0);
        pause = 0;
        expect_tick(1, 356, "t2_ch1_resume");
        expect_tick(0, 612, "t2_ch0_resume");
        do_stop();

        // Level changes apply only at reloads; level saturates at 7.
        do_start();
        level_up = 1; cycle(); cycle(); level_up = 0;
        check("t3_level2", 32'(level), 2);
        expect_tick(1, 256, "t3_ch1_a");
        expect_tick(1, 320, "t3_ch1_b");
        expect_tick(1, 384, "t3_ch1_c");
        expect_tick(0, 512, "t3_ch0_a");
        expect_tick(0, 640, "t3_ch0_b");
        level_up = 1; repeat (9) cycle(); level_up = 0;
        check("t3_level_sat", 32'(level), 7);
        expect_tick(1, 704, "t3_ch1_reload");
        expect_tick(1, 720, "t3_ch1_min");
        expect_tick(1, 736, "t3_ch1_min2");
        expect_tick(0, 768, "t3_ch0_reload");
        expect_tick(0, 784, "t3_ch0_min");
        do_stop();

        // Stop at edge 300 with level 2; restart shows level cleared and bases kept.
        do_start();
        level_up = 1; cycle(); cycle(); level_up = 0;
        while (edges < 299) cycle();
        do_stop();
        check_reset_vals("t5_stop");
        do_start();
        expect_tick(1, 256, "t5_restart_ch1");
        do_stop();

        // Runtime configuration: IDLE writes, ignored RUN write, PAUSED write deferred.
        cfg_valid = 1; cfg_ch = 1'b0; cfg_period = 10'd100; cycle();
        cfg_ch = 1'b1; cfg_period = 10'd5; cycle();
        cfg_valid = 0;
        do_start();
        expect_tick(1, 16, "t4_ch1_a");
        expect_tick(1, 32, "t4_ch1_b");
        expect_tick(0, 100, "t4_ch0_a");
        check("t4_cfg_ready_run", 32'(cfg_ready), 0);
        cfg_valid = 1; cfg_ch = 1'b0; cfg_period = 10'd50; cycle(); cfg_valid = 0;
        expect_tick(0, 200, "t4_ch0_b");
        pause = 1; cycle();
        cfg_valid = 1; cfg_ch = 1'b0; cfg_period = 10'd30; cycle(); cfg_valid = 0;
        pause = 0; cycle();
        expect_tick(0, 302, "t4_ch0_live");
        expect_tick(0, 332, "t4_ch0_new");

        // Synchronous reset mid-run restores the default base period.
        reset = 1; cycle(); reset = 0;
        check_reset_vals("t6_reset");
`ifdef TICK_TOTAL_EN
        check("t6_tick_total", 32'(tick_total), 0);
`endif
        do_start();
        expect_tick(0, 512, "t6_ch0_default");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
